// File: rtl/memwb_pipe_reg_if.sv
// MEM/WB boundary bundle: MEM-stage results in, write-back signals out.
// master drives the MEM side; slave is the pipeline register.
interface memwb_pipe_reg_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CTRL_W     = 22,
   parameter int CNT_W      = 32
);
   logic                  in_valid;
   logic [CTRL_W-1:0]     ctrl_in;
   logic [DATA_W-1:0]     mem_data_in;
   logic [DATA_W-1:0]     alu_in;
   logic [DATA_W-1:0]     pc_in;
   logic [REG_ADDR_W-1:0] rd_in;
   logic                  rf_en_in;
   logic                  hi_en_in;
   logic                  lo_en_in;
   logic [1:0]            wb_sel_in;
   logic [1:0]            ld_size_in;
   logic                  ld_unsigned_in;
   logic [1:0]            addr_lo_in;

   logic [CTRL_W-1:0]     ctrl_out;
   logic [DATA_W-1:0]     wb_data_out;
   logic [REG_ADDR_W-1:0] wb_rd_out;
   logic                  rf_en_out;
   logic                  hi_en_out;
   logic                  lo_en_out;
   logic                  wb_valid_out;
   logic [CNT_W-1:0]      retire_count;

   modport master (
      output in_valid, ctrl_in, mem_data_in,
      output alu_in, pc_in, rd_in,
      output rf_en_in, hi_en_in, lo_en_in,
      output wb_sel_in, ld_size_in,
      output ld_unsigned_in, addr_lo_in,
      input  ctrl_out, wb_data_out, wb_rd_out,
      input  rf_en_out, hi_en_out, lo_en_out,
      input  wb_valid_out, retire_count
   );

   modport slave (
      input  in_valid, ctrl_in, mem_data_in,
      input  alu_in, pc_in, rd_in,
      input  rf_en_in, hi_en_in, lo_en_in,
      input  wb_sel_in, ld_size_in,
      input  ld_unsigned_in, addr_lo_in,
      output ctrl_out, wb_data_out, wb_rd_out,
      output rf_en_out, hi_en_out, lo_en_out,
      output wb_valid_out, retire_count
   );
endinterface

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with write-back select, big-endian
// sub-word load extraction, stall/flush, $zero guard and retire counter.
module memwb_pipe_reg #(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int CTRL_W      = 22,
   parameter int LINK_OFFSET = 8,
   parameter int ZERO_GUARD  = 1,
   parameter int CNT_W       = 32
) (
   input logic clk,
   input logic reset,
   input logic stall,
   input logic flush,
   memwb_pipe_reg_if.slave bus
);

   localparam logic ZG = (ZERO_GUARD != 0);

   logic [DATA_W-1:0]     ld_data;
   logic [DATA_W-1:0]     link_data;
   logic [DATA_W-1:0]     sel_data;
   logic                  rd_zero;

   logic [CTRL_W-1:0]     ctrl_d, ctrl_q;
   logic [DATA_W-1:0]     data_d, data_q;
   logic [REG_ADDR_W-1:0] rd_d, rd_q;
   logic                  rf_d, rf_q;
   logic                  hi_d, hi_q;
   logic                  lo_d, lo_q;
   logic                  valid_d, valid_q;
   logic [CNT_W-1:0]      cnt_d, cnt_q;

   generate
      if (DATA_W == 32) begin : g_subword
         logic [7:0]  byte_v;
         logic [15:0] half_v;

         always_comb begin
            byte_v = bus.mem_data_in[31:24];
            unique case (bus.addr_lo_in)
               2'd0: byte_v = bus.mem_data_in[31:24];
               2'd1: byte_v = bus.mem_data_in[23:16];
               2'd2: byte_v = bus.mem_data_in[15:8];
               2'd3: byte_v = bus.mem_data_in[7:0];
               default: byte_v = bus.mem_data_in[31:24];
            endcase
            // addr bit 0 ignored: misaligned halves are not trapped
            half_v = bus.addr_lo_in[1] ? bus.mem_data_in[15:0]
                                       : bus.mem_data_in[31:16];
         end

         always_comb begin
            ld_data = bus.mem_data_in;
            unique case (1'b1)
               (bus.ld_size_in == 2'b01):
                  ld_data = bus.ld_unsigned_in
                          ? {16'b0, half_v}
                          : {{16{half_v[15]}}, half_v};
               (bus.ld_size_in == 2'b10):
                  ld_data = bus.ld_unsigned_in
                          ? {24'b0, byte_v}
                          : {{24{byte_v[7]}}, byte_v};
               default:
                  ld_data = bus.mem_data_in;
            endcase
         end
      end else begin : g_word_only
         assign ld_data = bus.mem_data_in;
      end
   endgenerate

   assign link_data = bus.pc_in + DATA_W'(LINK_OFFSET);

   always_comb begin
      sel_data = bus.alu_in;
      unique case (1'b1)
         (bus.wb_sel_in == 2'b01): sel_data = ld_data;
         (bus.wb_sel_in == 2'b10): sel_data = link_data;
         default:                  sel_data = bus.alu_in;
      endcase
   end

   assign rd_zero = (bus.rd_in == '0);

   // Flush beats stall so a held instruction can be squashed.
   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      rd_d    = rd_q;
      rf_d    = rf_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (flush) begin
         ctrl_d  = '0;
         data_d  = '0;
         rd_d    = '0;
         rf_d    = 1'b0;
         hi_d    = 1'b0;
         lo_d    = 1'b0;
         valid_d = 1'b0;
      end else if (!stall) begin
         ctrl_d  = bus.ctrl_in;
         data_d  = sel_data;
         rd_d    = bus.rd_in;
         rf_d    = bus.rf_en_in & bus.in_valid
                 & ~(ZG & rd_zero);
         hi_d    = bus.hi_en_in & bus.in_valid;
         lo_d    = bus.lo_en_in & bus.in_valid;
         valid_d = bus.in_valid;
         cnt_d   = cnt_q + CNT_W'(bus.in_valid);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= '0;
         data_q  <= '0;
         rd_q    <= '0;
         rf_q    <= 1'b0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         rf_q    <= rf_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ctrl_out     = ctrl_q;
   assign bus.wb_data_out  = data_q;
   assign bus.wb_rd_out    = rd_q;
   assign bus.rf_en_out    = rf_q;
   assign bus.hi_en_out    = hi_q;
   assign bus.lo_en_out    = lo_q;
   assign bus.wb_valid_out = valid_q;
   assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Directed bench for memwb_pipe_reg (CNT_W=4 so the counter wraps).
// Each task drives a scenario and checks outputs one cycle later.
module tb_memwb_pipe_reg;

   logic clk;
   logic reset;
   logic stall;
   logic flush;
   int   n_pass;
   int   n_total;
   logic [3:0] exp_cnt;

   memwb_pipe_reg_if #(.CNT_W(4)) bus ();

   memwb_pipe_reg #(.CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(
      input logic        v,
      input logic [31:0] alu,
      input logic [4:0]  rd,
      input logic [1:0]  sel
   );
      bus.in_valid       = v;
      bus.ctrl_in        = 22'h2A5A5;
      bus.mem_data_in    = 32'h80FF_7F01;
      bus.alu_in         = alu;
      bus.pc_in          = 32'h0000_1000;
      bus.rd_in          = rd;
      bus.rf_en_in       = 1'b1;
      bus.hi_en_in       = 1'b1;
      bus.lo_en_in       = 1'b1;
      bus.wb_sel_in      = sel;
      bus.ld_size_in     = 2'b00;
      bus.ld_unsigned_in = 1'b0;
      bus.addr_lo_in     = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      set_instr(1'b1, 32'hDEAD_BEEF, 5'd9, 2'b00);
      step();
      step();
      reset = 1'b1;
      step();
      n_total++;
      if (bus.wb_valid_out !== 1'b1 || bus.wb_data_out !== 32'hDEAD_BEEF) begin
         $display("FAIL pre_reset_load valid=%b data=%h want 1 deadbeef",
                  bus.wb_valid_out, bus.wb_data_out);
      end else n_pass++;
      #3 reset = 1'b0;
      #1;
      n_total++;
      if (bus.wb_data_out !== 32'h0 || bus.wb_valid_out !== 1'b0
          || bus.ctrl_out !== 22'h0 || bus.wb_rd_out !== 5'h0) begin
         $display("FAIL async_reset_data data=%h v=%b ctrl=%h rd=%h want 0",
                  bus.wb_data_out, bus.wb_valid_out, bus.ctrl_out, bus.wb_rd_out);
      end else n_pass++;
      n_total++;
      if ({bus.rf_en_out, bus.hi_en_out, bus.lo_en_out} !== 3'b000
          || bus.retire_count !== 4'h0) begin
         $display("FAIL async_reset_en en=%b%b%b cnt=%0d want 000 0",
                  bus.rf_en_out, bus.hi_en_out, bus.lo_en_out, bus.retire_count);
      end else n_pass++;
      step();
      reset = 1'b1;
      exp_cnt = 4'd0;
      set_instr(1'b1, 32'h1234_5678, 5'd3, 2'b00);
      step();
      exp_cnt++;
      n_total++;
      if (bus.wb_data_out !== 32'h1234_5678 || bus.rf_en_out !== 1'b1
          || bus.retire_count !== 4'd1 || bus.wb_rd_out !== 5'd3) begin
         $display("FAIL first_load data=%h rf=%b cnt=%0d rd=%0d want 12345678 1 1 3",
                  bus.wb_data_out, bus.rf_en_out, bus.retire_count, bus.wb_rd_out);
      end else n_pass++;
      n_total++;
      if (bus.ctrl_out !== 22'h2A5A5) begin
         $display("FAIL ctrl_pass got=%h want 2a5a5", bus.ctrl_out);
      end else n_pass++;
   endtask

   task automatic test_subword();
      logic [1:0]  sz  [9] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b01, 2'b11};
      logic [1:0]  ad  [9] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1,
                               2'd3, 2'd1, 2'd3, 2'd2};
      logic        un  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] exp [9] = '{32'hFFFF_FF80, 32'h0000_007F,
                               32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01, 32'h0000_0001,
                               32'hFFFF_FFFF, 32'h0000_7F01,
                               32'h80FF_7F01};
      set_instr(1'b1, 32'h0, 5'd5, 2'b01);
      for (int i = 0; i < 9; i++) begin
         bus.ld_size_in     = sz[i];
         bus.addr_lo_in     = ad[i];
         bus.ld_unsigned_in = un[i];
         step();
         exp_cnt++;
         n_total++;
         if (bus.wb_data_out !== exp[i]) begin
            $display("FAIL subword_%0d sz=%b a=%0d u=%b got=%h want=%h",
                     i, sz[i], ad[i], un[i], bus.wb_data_out, exp[i]);
         end else n_pass++;
      end
   endtask

   task automatic test_link();
      set_instr(1'b1, 32'h5555_5555, 5'd31, 2'b10);
      bus.pc_in = 32'hFFFF_FFFC;
      step();
      exp_cnt++;
      n_total++;
      if (bus.wb_data_out !== 32'h0000_0004) begin
         $display("FAIL link_wrap got=%h want=00000004", bus.wb_data_out);
      end else n_pass++;
      bus.wb_sel_in = 2'b11;
      step();
      exp_cnt++;
      n_total++;
      if (bus.wb_data_out !== 32'h5555_5555) begin
         $display("FAIL sel11_alu got=%h want=55555555", bus.wb_data_out);
      end else n_pass++;
   endtask

   task automatic test_stall();
      set_instr(1'b1, 32'hAAAA_0001, 5'd7, 2'b00);
      step();
      exp_cnt++;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1'b1, 32'h0BAD_0000 + i, 5'd12, 2'b00);
         bus.ctrl_in = 22'h1;
         step();
         n_total++;
         if (bus.wb_data_out !== 32'hAAAA_0001 || bus.wb_rd_out !== 5'd7
             || bus.ctrl_out !== 22'h2A5A5 || bus.wb_valid_out !== 1'b1
             || bus.retire_count !== exp_cnt) begin
            $display("FAIL stall_hold_%0d data=%h rd=%0d ctrl=%h cnt=%0d want aaaa0001 7 2a5a5 %0d",
                     i, bus.wb_data_out, bus.wb_rd_out, bus.ctrl_out,
                     bus.retire_count, exp_cnt);
         end else n_pass++;
      end
      stall = 1'b0;
      step();
      exp_cnt++;
      n_total++;
      if (bus.wb_data_out !== 32'h0BAD_0002 || bus.retire_count !== exp_cnt) begin
         $display("FAIL stall_release data=%h cnt=%0d want 0bad0002 %0d",
                  bus.wb_data_out, bus.retire_count, exp_cnt);
      end else n_pass++;
   endtask

   task automatic test_stall_flush();
      stall = 1'b1;
      flush = 1'b1;
      step();
      n_total++;
      if (bus.wb_valid_out !== 1'b0
          || {bus.rf_en_out, bus.hi_en_out, bus.lo_en_out} !== 3'b000
          || bus.wb_data_out !== 32'h0 || bus.ctrl_out !== 22'h0
          || bus.retire_count !== exp_cnt) begin
         $display("FAIL stall_flush v=%b en=%b%b%b data=%h cnt=%0d want 0 000 0 %0d",
                  bus.wb_valid_out, bus.rf_en_out, bus.hi_en_out,
                  bus.lo_en_out, bus.wb_data_out, bus.retire_count, exp_cnt);
      end else n_pass++;
      stall = 1'b0;
      step();
      n_total++;
      if (bus.wb_valid_out !== 1'b0 || bus.retire_count !== exp_cnt) begin
         $display("FAIL flush_only v=%b cnt=%0d want 0 %0d",
                  bus.wb_valid_out, bus.retire_count, exp_cnt);
      end else n_pass++;
      flush = 1'b0;
   endtask

   task automatic test_guards();
      set_instr(1'b1, 32'h0000_00AB, 5'd0, 2'b00);
      step();
      exp_cnt++;
      n_total++;
      if (bus.rf_en_out !== 1'b0 || bus.hi_en_out !== 1'b1
          || bus.wb_valid_out !== 1'b1 || bus.retire_count !== exp_cnt) begin
         $display("FAIL zero_guard rf=%b hi=%b v=%b cnt=%0d want 0 1 1 %0d",
                  bus.rf_en_out, bus.hi_en_out, bus.wb_valid_out,
                  bus.retire_count, exp_cnt);
      end else n_pass++;
      set_instr(1'b0, 32'h0000_00CD, 5'd4, 2'b00);
      step();
      n_total++;
      if ({bus.rf_en_out, bus.hi_en_out, bus.lo_en_out} !== 3'b000
          || bus.wb_valid_out !== 1'b0 || bus.retire_count !== exp_cnt) begin
         $display("FAIL invalid_gate en=%b%b%b v=%b cnt=%0d want 000 0 %0d",
                  bus.rf_en_out, bus.hi_en_out, bus.lo_en_out,
                  bus.wb_valid_out, bus.retire_count, exp_cnt);
      end else n_pass++;
   endtask

   task automatic test_wrap();
      reset = 1'b0;
      #2 reset = 1'b1;
      set_instr(1'b1, 32'h1, 5'd1, 2'b00);
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i == 16) begin
            n_total++;
            if (bus.retire_count !== 4'd0) begin
               $display("FAIL wrap_16 got=%0d want=0", bus.retire_count);
            end else n_pass++;
         end
      end
      n_total++;
      if (bus.retire_count !== 4'd1) begin
         $display("FAIL wrap_17 got=%0d want=1", bus.retire_count);
      end else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      exp_cnt = 4'd0;
      test_reset();
      test_subword();
      test_link();
      test_stall();
      test_stall_flush();
      test_guards();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/memwb_pipe_reg.md
# memwb_pipe_reg

Parametrised MEM/WB pipeline register for the five-stage MIPS datapath. It sits between the data-memory stage and register-file write-back. It latches MEM-stage results and control, and performs write-back source selection and sub-word load extraction/extension before the register. It adds stall, flush, a valid bit, a `$zero` write guard and a retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 32: datapath width. Sub-word loads are defined only for 32; other widths support word loads only.
- `REG_ADDR_W`, 5: register-file address width.
- `CTRL_W`, 22: width of the pass-through control bundle.
- `LINK_OFFSET`, 8: value added to `pc_in` for link write-back.
- `ZERO_GUARD`, 1: when 1, a write to register 0 is suppressed.
- `CNT_W`, 32: retired-instruction counter width.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: hold all state.
- `flush`, in, 1: load a bubble.
- `in_valid`, in, 1: the MEM-stage slot holds a real instruction.
- `ctrl_in`, in, CTRL_W: control bundle, passed through.
- `mem_data_in`, in, DATA_W: data-memory read word.
- `alu_in`, in, DATA_W: ALU result from MEM.
- `pc_in`, in, DATA_W: PC of the instruction.
- `rd_in`, in, REG_ADDR_W: destination register.
- `rf_en_in`, `hi_en_in`, `lo_en_in`, in, 1 each: write enables.
- `wb_sel_in`, in, 2: write-back source. 00 = ALU, 01 = MEM, 10 = LINK, 11 = ALU.
- `ld_size_in`, in, 2: load size. 00 = word, 01 = half, 10 = byte, 11 = word.
- `ld_unsigned_in`, in, 1: 1 = zero-extend, 0 = sign-extend.
- `addr_lo_in`, in, 2: low two bits of the load address.
- `ctrl_out`, out, CTRL_W: registered control bundle.
- `wb_data_out`, out, DATA_W: write-back data.
- `wb_rd_out`, out, REG_ADDR_W: write-back register.
- `rf_en_out`, `hi_en_out`, `lo_en_out`, out, 1 each: gated write enables.
- `wb_valid_out`, out, 1: the WB slot holds a real instruction.
- `retire_count`, out, CNT_W: count of valid instructions accepted into WB.

## Operation
- Load extraction is big-endian and combinational, before the register.
  - Byte lane k = `addr_lo_in`: k=0 selects [31:24], k=1 selects [23:16], k=2 selects [15:8], k=3 selects [7:0].
  - Halfword uses `addr_lo_in[1]`: 0 selects [31:16], 1 selects [15:0]. `addr_lo_in[0]` is ignored; a misaligned halfword is not trapped.
  - The extracted value is extended to DATA_W per `ld_unsigned_in`.
- LINK value is `pc_in + LINK_OFFSET`, modulo 2^DATA_W.
- Per-edge priority, highest first:
  1. Reset low: all outputs and state are 0.
  2. `flush`: `wb_valid_out`, all enables, `ctrl_out`, `wb_data_out` and `wb_rd_out` become 0. `retire_count` holds.
  3. `stall`: every register holds.
  4. Otherwise: load the selected data, `rd_in`, `ctrl_in` and `in_valid`. Each enable is the AND of its input with `in_valid`. `rf_en_out` is additionally forced to 0 when `ZERO_GUARD`=1 and `rd_in`=0.
- `retire_count` increments by 1 on each case-4 edge with `in_valid`=1. It wraps from all-ones to 0.
- Flush takes precedence over stall when both are asserted.
- A flush while stalled removes the held instruction. It is never counted.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Outputs are purely registered; there is no combinational input-to-output path.
- Reset is asserted asynchronously and takes effect immediately. Deassertion is synchronised outside this block. The first update occurs on the first rising edge with `reset` high.
- Reset mid-stall clears held state. After release the block resumes with an empty (invalid) slot.
- A stall of any length keeps the outputs stable. `retire_count` does not advance while stalled.

## Test plan
- Reset: drive `reset`=0 mid-cycle with nonzero inputs -> all outputs read 0 immediately. Release, present `in_valid`=1, `alu_in`=0x1234_5678, `wb_sel_in`=00, `rd_in`=3 -> one edge later `wb_data_out`=0x1234_5678, `rf_en_out`=1, `retire_count`=1.
- Sub-word loads with `mem_data_in`=0x80FF_7F01:
  - byte, `addr_lo_in`=0, signed -> 0xFFFF_FF80.
  - byte, `addr_lo_in`=2, unsigned -> 0x0000_007F.
  - half, `addr_lo_in`=0, signed -> 0xFFFF_80FF.
  - half, `addr_lo_in`=2, unsigned -> 0x0000_7F01.
- Link: `wb_sel_in`=10, `pc_in`=0xFFFF_FFFC -> `wb_data_out`=0x0000_0004.
- Stall/flush:
  - Stall for 3 cycles with changing inputs -> outputs and `retire_count` frozen.
  - Assert `stall` and `flush` together -> `wb_valid_out`=0, all enables 0, count unchanged.
- Guards:
  - `rd_in`=0 with `rf_en_in`=1 -> `rf_en_out`=0.
  - `in_valid`=0 with `hi_en_in`=1 -> `hi_en_out`=0.
- Counter wrap: with `CNT_W`=4, retire 17 valid instructions -> `retire_count`=1.
